// File: rtl/sram_wb_port0_ctrl.sv
// Wishbone classic slave driving port 0 (RW) of a 32-bit OpenRAM macro.
// Every access takes four cycles: issue, SRAM negedge access, capture/ack, recover.
module sram_wb_port0_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [DATA_WIDTH/8-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e                    state_q;
    logic                      op_we_q;
    logic                      ack_q;
    logic [DATA_WIDTH-1:0]     dat_q;
    logic                      csb_q;
    logic                      web_q;
    logic [DATA_WIDTH/8-1:0]   wmask_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     din_q;

    logic req_hit;
    logic unused_adr_lsb;

    assign req_hit = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            op_we_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_hit) begin
                        addr_q  <= wbs_adr_i[ADDR_WIDTH+1:2];
                        din_q   <= wbs_dat_i;
                        op_we_q <= wbs_we_i;
                        web_q   <= ~wbs_we_i;
                        wmask_q <= wbs_we_i ? wbs_sel_i : '0;
                        csb_q   <= 1'b0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    // Macro latched the request on this edge; release controls, hold addr/din.
                    csb_q   <= 1'b1;
                    web_q   <= 1'b1;
                    wmask_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (!op_we_q) begin
                        dat_q <= sram_dout0;
                    end
                    ack_q   <= wbs_cyc_i;
                    state_q <= StAck;
                end
                StAck: begin
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

endmodule

// File: tb/tb_sram_wb_port0_ctrl.sv
// Bench for sram_wb_port0_ctrl: behavioural SRAM model, bus master tasks and an
// ack-driven scoreboard that checks wbs_dat_o against queued expectations.
module tb_sram_wb_port0_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_wb_port0_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .sram_csb0   (csb),
        .sram_web0   (web),
        .sram_wmask0 (wmask),
        .sram_addr0  (addr0),
        .sram_din0   (din0),
        .sram_dout0  (dout0)
    );

    // SRAM model: inputs registered on posedge, array access on the following negedge.
    logic [31:0] mem [512];
    logic        m_pend = 1'b0;
    logic        m_we;
    logic [8:0]  m_addr;
    logic [31:0] m_din;
    logic [3:0]  m_mask;

    always @(posedge clk) begin
        m_pend <= (csb === 1'b0);
        m_we   <= ~web;
        m_addr <= addr0;
        m_din  <= din0;
        m_mask <= wmask;
    end

    always @(negedge clk) begin
        if (m_pend) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_mask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
                end
            end else begin
                dout0 <= mem[m_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Scoreboard: one expected wbs_dat_o value per acked transfer.
    logic [31:0] exp_q[$];
    logic [31:0] exp_dat = 32'h0;
    logic [31:0] mon_exp;
    int          ack_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (ack === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 with dat_o=%h, want no ack", dat_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("ack_data", dat_o, mon_exp);
            end
        end
    end

    // Chip-select monitor: records each access pulse and checks pulse width.
    int         cyc_cnt = 0;
    int         low_cnt = 0;
    int         last_low_cyc = 0;
    logic       prev_low = 1'b0;
    logic       cap_web;
    logic [3:0] cap_wmask;
    logic [8:0] cap_addr;

    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        if (csb === 1'b0) begin
            chk("csb_single_cycle", {31'b0, prev_low}, 32'h0);
            low_cnt++;
            last_low_cyc = cyc_cnt;
            cap_web   = web;
            cap_wmask = wmask;
            cap_addr  = addr0;
        end
        prev_low = (csb === 1'b0);
    end

    task automatic wait_ack(input int limit, output int k, output bit got);
        k   = 0;
        got = 1'b0;
        while (!got && k < limit) begin
            @(posedge clk);
            #1;
            k++;
            got = (ack === 1'b1);
        end
    endtask

    // One classic transfer issued while the controller is idle; ack expected 3 edges on.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string name);
        int k;
        bit got;
        @(negedge clk);
        if (!w) exp_dat = exp_rd;
        exp_q.push_back(exp_dat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        wait_ack(20, k, got);
        chk({name, "_ack_latency"}, k, 32'd3);
        if (!got) void'(exp_q.pop_back());
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
    endtask

    task automatic miss(input logic [31:0] a, input string name);
        int a0, l0;
        a0 = ack_cnt;
        l0 = low_cnt;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        repeat (10) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        chk({name, "_no_ack"}, ack_cnt - a0, 32'd0);
        chk({name, "_no_csb"}, low_cnt - l0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  l0, a0, k, first_low;
        bit  got;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        dout0 = 32'h0;

        // Reset held two cycles with a hitting request on the bus.
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        adr = 32'h3000_0010; sel = 4'hF; dat_i = 32'h5555_AAAA;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_ack", {31'b0, ack}, 32'h0);
            chk("rst_dat", dat_o, 32'h0);
            chk("rst_csb", {31'b0, csb}, 32'h1);
            chk("rst_web", {31'b0, web}, 32'h1);
            chk("rst_wmask", {28'b0, wmask}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        chk("rst_no_access", low_cnt, 32'd0);

        // Full write then read back.
        l0 = low_cnt;
        xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, "wr_full");
        chk("wr_full_pulses", low_cnt - l0, 32'd1);
        chk("wr_full_addr", {23'b0, cap_addr}, 32'd4);
        chk("wr_full_web", {31'b0, cap_web}, 32'h0);
        chk("wr_full_wmask", {28'b0, cap_wmask}, 32'hF);
        xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, "rd_full");
        chk("rd_web", {31'b0, cap_web}, 32'h1);
        chk("rd_wmask", {28'b0, cap_wmask}, 32'h0);

        // Byte-lane merge, then an all-lanes-off write that must leave memory alone.
        xfer(1'b1, 32'h3000_0012, 4'b0101, 32'h1122_3344, 32'h0, "wr_mask");
        chk("wr_mask_wmask", {28'b0, cap_wmask}, 32'h5);
        xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDE22_BE44, "rd_mask");
        xfer(1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, "wr_sel0");
        chk("wr_sel0_web", {31'b0, cap_web}, 32'h0);
        chk("wr_sel0_wmask", {28'b0, cap_wmask}, 32'h0);
        xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDE22_BE44, "rd_sel0");

        miss(32'h3000_0800, "miss_above");
        miss(32'h2000_0000, "miss_below");

        // Master abort after the request is sampled: write lands, no ack.
        a0 = ack_cnt;
        l0 = low_cnt;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_07FC; sel = 4'hF;
        dat_i = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_ack", ack_cnt - a0, 32'd0);
        chk("abort_pulses", low_cnt - l0, 32'd1);
        chk("abort_addr", {23'b0, cap_addr}, 32'd511);
        xfer(1'b0, 32'h3000_07FC, 4'hF, 32'h0, 32'hCAFE_F00D, "rd_abort");

        // Back-to-back with stb held: second request sampled 4 cycles after the first.
        @(negedge clk);
        exp_q.push_back(exp_dat);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; sel = 4'hF;
        dat_i = 32'h0000_0001;
        wait_ack(20, k, got);
        chk("b2b_wr_latency", k, 32'd3);
        if (!got) void'(exp_q.pop_back());
        first_low = last_low_cyc;
        exp_dat = 32'h0000_0001;
        exp_q.push_back(exp_dat);
        we = 1'b0;
        wait_ack(20, k, got);
        chk("b2b_rd_latency", k, 32'd4);
        if (!got) void'(exp_q.pop_back());
        chk("b2b_spacing", last_low_cyc - first_low, 32'd4);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
